// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin arbiter for the AXI3 read path (AR/R) in front of one slave.
// One transaction in flight; slave ARID carries the grant index; beat count checked against ARLEN.
module axi_rd_arbiter #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_DWIDTH = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // master 0
  input  logic [ID_WIDTH-1:0]   M0_ARID,
  input  logic [31:0]           M0_ARADDR,
  input  logic [3:0]            M0_ARLEN,
  input  logic [2:0]            M0_ARSIZE,
  input  logic [1:0]            M0_ARBURST,
  input  logic                  M0_ARVALID,
  output logic                  M0_ARREADY,
  output logic [ID_WIDTH-1:0]   M0_RID,
  output logic [AXI_DWIDTH-1:0] M0_RDATA,
  output logic [1:0]            M0_RRESP,
  output logic                  M0_RLAST,
  output logic                  M0_RVALID,
  input  logic                  M0_RREADY,
  // master 1
  input  logic [ID_WIDTH-1:0]   M1_ARID,
  input  logic [31:0]           M1_ARADDR,
  input  logic [3:0]            M1_ARLEN,
  input  logic [2:0]            M1_ARSIZE,
  input  logic [1:0]            M1_ARBURST,
  input  logic                  M1_ARVALID,
  output logic                  M1_ARREADY,
  output logic [ID_WIDTH-1:0]   M1_RID,
  output logic [AXI_DWIDTH-1:0] M1_RDATA,
  output logic [1:0]            M1_RRESP,
  output logic                  M1_RLAST,
  output logic                  M1_RVALID,
  input  logic                  M1_RREADY,
  // slave
  output logic [ID_WIDTH:0]     S_ARID,
  output logic [31:0]           S_ARADDR,
  output logic [3:0]            S_ARLEN,
  output logic [2:0]            S_ARSIZE,
  output logic [1:0]            S_ARBURST,
  output logic                  S_ARVALID,
  input  logic                  S_ARREADY,
  input  logic [ID_WIDTH:0]     S_RID,
  input  logic [AXI_DWIDTH-1:0] S_RDATA,
  input  logic [1:0]            S_RRESP,
  input  logic                  S_RLAST,
  input  logic                  S_RVALID,
  output logic                  S_RREADY,
  output logic                  BUSY,
  output logic                  LEN_ERR
);

  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state_q, state_d;
  logic                 ptr_q;
  logic                 gnt_q;
  logic                 gnt_c;
  logic [CNT_WIDTH-1:0] beat_cnt_q;
  logic [CNT_WIDTH-1:0] exp_len_q;
  logic                 ar_hs_c;
  logic                 r_hs_c;
  logic                 r0_sel_c;
  logic                 r1_sel_c;
  logic                 rid_unused_c;

  // Routing uses the latched grant, so the slave's RID top bit is ignored.
  assign rid_unused_c = S_RID[ID_WIDTH];

  // Grant selection: lone requester wins, contention goes to the pointer.
  always_comb begin
    gnt_c = 1'b0;
    if (M0_ARVALID && M1_ARVALID) gnt_c = ptr_q;
    else if (M1_ARVALID)          gnt_c = 1'b1;
  end

  assign M0_ARREADY = (state_q == IDLE) && !ARESET && M0_ARVALID && !gnt_c;
  assign M1_ARREADY = (state_q == IDLE) && !ARESET && M1_ARVALID &&  gnt_c;
  assign ar_hs_c    = M0_ARREADY || M1_ARREADY;

  // R channel steering to the owner of the current burst.
  assign r0_sel_c  = (state_q == DATA) && !gnt_q;
  assign r1_sel_c  = (state_q == DATA) &&  gnt_q;
  assign S_RREADY  = (r0_sel_c && M0_RREADY) || (r1_sel_c && M1_RREADY);
  assign r_hs_c    = S_RVALID && S_RREADY;

  assign M0_RVALID = r0_sel_c && S_RVALID;
  assign M0_RID    = r0_sel_c ? S_RID[ID_WIDTH-1:0] : '0;
  assign M0_RDATA  = r0_sel_c ? S_RDATA : '0;
  assign M0_RRESP  = r0_sel_c ? S_RRESP : 2'b00;
  assign M0_RLAST  = r0_sel_c && S_RLAST;

  assign M1_RVALID = r1_sel_c && S_RVALID;
  assign M1_RID    = r1_sel_c ? S_RID[ID_WIDTH-1:0] : '0;
  assign M1_RDATA  = r1_sel_c ? S_RDATA : '0;
  assign M1_RRESP  = r1_sel_c ? S_RRESP : 2'b00;
  assign M1_RLAST  = r1_sel_c && S_RLAST;

  assign BUSY = (state_q != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ar_hs_c)            state_d = ADDR;
      ADDR:    if (S_ARREADY)          state_d = DATA;
      DATA:    if (r_hs_c && S_RLAST)  state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Address registers, grant bookkeeping, beat counting and length check.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_ARID     <= '0;
      S_ARADDR   <= '0;
      S_ARLEN    <= '0;
      S_ARSIZE   <= '0;
      S_ARBURST  <= '0;
      S_ARVALID  <= 1'b0;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      beat_cnt_q <= '0;
      exp_len_q  <= '0;
      LEN_ERR    <= 1'b0;
    end else begin
      LEN_ERR <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ar_hs_c) begin
            gnt_q     <= gnt_c;
            S_ARID    <= gnt_c ? {1'b1, M1_ARID} : {1'b0, M0_ARID};
            S_ARADDR  <= gnt_c ? M1_ARADDR  : M0_ARADDR;
            S_ARLEN   <= gnt_c ? M1_ARLEN   : M0_ARLEN;
            S_ARSIZE  <= gnt_c ? M1_ARSIZE  : M0_ARSIZE;
            S_ARBURST <= gnt_c ? M1_ARBURST : M0_ARBURST;
            exp_len_q <= gnt_c ? M1_ARLEN   : M0_ARLEN;
            S_ARVALID <= 1'b1;
          end
        end
        ADDR: begin
          if (S_ARREADY) begin
            S_ARVALID  <= 1'b0;
            beat_cnt_q <= '0;
          end
        end
        DATA: begin
          if (r_hs_c) begin
            if (beat_cnt_q != CNT_WIDTH'(15)) beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            if (S_RLAST) begin
              LEN_ERR <= (beat_cnt_q != exp_len_q);
              ptr_q   <= ~gnt_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter: single read, contention, backpressure,
// address stall, length error and reset mid-burst.
module tb_axi_rd_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  M0_ARID, M1_ARID;
  logic [31:0] M0_ARADDR, M1_ARADDR;
  logic [3:0]  M0_ARLEN, M1_ARLEN;
  logic [2:0]  M0_ARSIZE, M1_ARSIZE;
  logic [1:0]  M0_ARBURST, M1_ARBURST;
  logic        M0_ARVALID, M1_ARVALID;
  logic        M0_ARREADY, M1_ARREADY;
  logic [3:0]  M0_RID, M1_RID;
  logic [63:0] M0_RDATA, M1_RDATA;
  logic [1:0]  M0_RRESP, M1_RRESP;
  logic        M0_RLAST, M1_RLAST;
  logic        M0_RVALID, M1_RVALID;
  logic        M0_RREADY, M1_RREADY;
  logic [4:0]  S_ARID;
  logic [31:0] S_ARADDR;
  logic [3:0]  S_ARLEN;
  logic [2:0]  S_ARSIZE;
  logic [1:0]  S_ARBURST;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [4:0]  S_RID;
  logic [63:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RLAST;
  logic        S_RVALID;
  logic        S_RREADY;
  logic        BUSY;
  logic        LEN_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter #(.ID_WIDTH(4), .AXI_DWIDTH(64)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
    .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
    .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .BUSY(BUSY), .LEN_ERR(LEN_ERR)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Master m raises ARVALID and waits (bounded) for its ARREADY; returns at the next negedge.
  task automatic issue(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len);
    logic got;
    got = 1'b0;
    if (m == 0) begin
      M0_ARID = id; M0_ARADDR = addr; M0_ARLEN = len; M0_ARSIZE = 3'd3; M0_ARBURST = 2'd1;
      M0_ARVALID = 1'b1;
    end else begin
      M1_ARID = id; M1_ARADDR = addr; M1_ARLEN = len; M1_ARSIZE = 3'd3; M1_ARBURST = 2'd1;
      M1_ARVALID = 1'b1;
    end
    for (int n = 0; n < 50 && !got; n++) begin
      #1;
      got = (m == 0) ? M0_ARREADY : M1_ARREADY;
      if (!got) @(negedge ACLK);
    end
    check("ar_grant", 64'(got), 64'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    if (m == 0) M0_ARVALID = 1'b0; else M1_ARVALID = 1'b0;
  endtask

  // Slave accepts the address after `stall` cycles, checking the AR payload stays put.
  task automatic slave_addr(input int stall, input logic [4:0] exp_id,
                            input logic [31:0] exp_addr, input logic [3:0] exp_len);
    for (int n = 0; n < 50 && !S_ARVALID; n++) @(negedge ACLK);
    check("s_arvalid", 64'(S_ARVALID), 64'd1);
    check("s_arid", 64'(S_ARID), 64'(exp_id));
    check("s_araddr", 64'(S_ARADDR), 64'(exp_addr));
    check("s_arlen", 64'(S_ARLEN), 64'(exp_len));
    for (int i = 0; i < stall; i++) begin
      S_ARREADY = 1'b0;
      M0_RREADY = 1'b1;
      M1_RREADY = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      check("stall_arvalid", 64'(S_ARVALID), 64'd1);
      check("stall_araddr", 64'(S_ARADDR), 64'(exp_addr));
      check("stall_arready", 64'({M0_ARREADY, M1_ARREADY}), 64'd0);
      check("stall_rready", 64'(S_RREADY), 64'd0);
      check("stall_busy", 64'(BUSY), 64'd1);
    end
    M0_RREADY = 1'b0;
    M1_RREADY = 1'b0;
    S_ARREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_ARREADY = 1'b0;
    check("ar_drop", 64'(S_ARVALID), 64'd0);
  endtask

  // Slave returns nbeats (RLAST on the final one); master m consumes, optionally 1-in-3 ready.
  task automatic slave_data(input int m, input logic [4:0] id, input int nbeats,
                            input logic [63:0] base, input bit bp);
    int  beat;
    logic rdy;
    beat = 0;
    for (int cyc = 0; cyc < 200 && beat < nbeats; cyc++) begin
      S_RVALID = 1'b1;
      S_RDATA  = base + 64'(beat);
      S_RLAST  = (beat == nbeats - 1);
      S_RID    = id;
      S_RRESP  = 2'b00;
      rdy = bp ? ((cyc % 3) == 0) : 1'b1;
      if (m == 0) M0_RREADY = rdy; else M1_RREADY = rdy;
      #1;
      check("s_rready", 64'(S_RREADY), 64'(rdy));
      check("own_rvalid", 64'(m == 0 ? M0_RVALID : M1_RVALID), 64'd1);
      check("other_rvalid", 64'(m == 0 ? M1_RVALID : M0_RVALID), 64'd0);
      if (rdy) begin
        check("rdata", m == 0 ? M0_RDATA : M1_RDATA, base + 64'(beat));
        check("rid", 64'(m == 0 ? M0_RID : M1_RID), 64'(id[3:0]));
        check("rlast", 64'(m == 0 ? M0_RLAST : M1_RLAST), 64'(beat == nbeats - 1));
        beat++;
      end
      @(posedge ACLK);
      @(negedge ACLK);
    end
    check("beats", 64'(beat), 64'(nbeats));
    S_RVALID = 1'b0;
    S_RLAST  = 1'b0;
    M0_RREADY = 1'b0;
    M1_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] id_exp;
    int         m;
    ARESET = 1'b1;
    {M0_ARID, M0_ARADDR, M0_ARLEN, M0_ARSIZE, M0_ARBURST, M0_RREADY} = '0;
    {M1_ARID, M1_ARADDR, M1_ARLEN, M1_ARSIZE, M1_ARBURST, M1_RREADY} = '0;
    M0_ARVALID = 1'b1;
    M1_ARVALID = 1'b0;
    {S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID} = '0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_arready", 64'(M0_ARREADY), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_arvalid", 64'(S_ARVALID), 64'd0);
    check("rst_araddr", 64'(S_ARADDR), 64'd0);
    check("rst_arid", 64'(S_ARID), 64'd0);
    check("rst_len_err", 64'(LEN_ERR), 64'd0);
    check("rst_rready", 64'(S_RREADY), 64'd0);
    M0_ARVALID = 1'b0;
    ARESET = 1'b0;

    // single read
    issue(0, 4'd3, 32'h100, 4'd0);
    check("single_busy", 64'(BUSY), 64'd1);
    slave_addr(0, 5'h03, 32'h100, 4'd0);
    slave_data(0, 5'h03, 1, 64'hAAAA5555AAAA5555, 1'b0);
    check("single_len_err", 64'(LEN_ERR), 64'd0);
    check("single_busy_end", 64'(BUSY), 64'd0);

    // contention from reset release
    ARESET = 1'b1;
    M0_ARID = 4'd1; M0_ARADDR = 32'h2000; M0_ARLEN = 4'd1; M0_ARVALID = 1'b1;
    M1_ARID = 4'd2; M1_ARADDR = 32'h3000; M1_ARLEN = 4'd1; M1_ARVALID = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int g = 0; g < 6; g++) begin
      for (int n = 0; n < 50 && !S_ARVALID; n++) @(negedge ACLK);
      m = g % 2;
      check("grant_order", 64'(S_ARID[4]), 64'(m));
      id_exp = (m == 0) ? 5'h01 : 5'h12;
      if (g == 4) M0_ARVALID = 1'b0;
      if (g == 5) M1_ARVALID = 1'b0;
      slave_addr(0, id_exp, (m == 0) ? 32'h2000 : 32'h3000, 4'd1);
      slave_data(m, id_exp, 2, 64'h1000 * 64'(g), 1'b0);
      check("cont_len_err", 64'(LEN_ERR), 64'd0);
    end

    // backpressure on M1 (pointer now M0, only M1 requests)
    issue(1, 4'd5, 32'h4000, 4'd3);
    slave_addr(0, 5'h15, 32'h4000, 4'd3);
    slave_data(1, 5'h15, 4, 64'h5000, 1'b1);
    check("bp_len_err", 64'(LEN_ERR), 64'd0);

    // address stall with M1 also requesting
    M1_ARID = 4'd9; M1_ARADDR = 32'h9000; M1_ARLEN = 4'd0; M1_ARVALID = 1'b1;
    issue(0, 4'd6, 32'h6000, 4'd0);
    slave_addr(5, 5'h06, 32'h6000, 4'd0);
    M1_ARVALID = 1'b0;
    slave_data(0, 5'h06, 1, 64'h6600, 1'b0);

    // length error: ARLEN=3 but RLAST on beat 2
    issue(1, 4'd4, 32'h7000, 4'd3);
    slave_addr(0, 5'h14, 32'h7000, 4'd3);
    slave_data(1, 5'h14, 2, 64'h7700, 1'b0);
    check("len_err_pulse", 64'(LEN_ERR), 64'd1);
    check("len_err_idle", 64'(BUSY), 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    check("len_err_clear", 64'(LEN_ERR), 64'd0);
    issue(0, 4'd2, 32'h8000, 4'd0);
    slave_addr(0, 5'h02, 32'h8000, 4'd0);
    slave_data(0, 5'h02, 1, 64'h8800, 1'b0);
    check("after_err_len_err", 64'(LEN_ERR), 64'd0);

    // reset mid-burst (pointer is M1 beforehand)
    issue(1, 4'd7, 32'hA000, 4'd3);
    slave_addr(0, 5'h17, 32'hA000, 4'd3);
    S_RVALID = 1'b1; S_RID = 5'h17; S_RDATA = 64'hA0; S_RLAST = 1'b0; M1_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b1;
    M1_ARVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    check("mid_rst_rvalid", 64'(M1_RVALID), 64'd0);
    check("mid_rst_rready", 64'(S_RREADY), 64'd0);
    check("mid_rst_arvalid", 64'(S_ARVALID), 64'd0);
    check("mid_rst_arid", 64'(S_ARID), 64'd0);
    check("mid_rst_arready", 64'(M1_ARREADY), 64'd0);
    S_RVALID = 1'b0; M1_RREADY = 1'b0; M1_ARVALID = 1'b0;
    ARESET = 1'b0;
    M0_ARVALID = 1'b1; M1_ARVALID = 1'b1;
    #1;
    check("ptr_reset_m0", 64'({M0_ARREADY, M1_ARREADY}), 64'd2);
    M0_ARVALID = 1'b0;
    issue(1, 4'd8, 32'hB000, 4'd0);
    slave_addr(0, 5'h18, 32'hB000, 4'd0);
    slave_data(1, 5'h18, 1, 64'hBB00, 1'b0);
    check("final_busy", 64'(BUSY), 64'd0);
    check("final_len_err", 64'(LEN_ERR), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master, one-slave arbiter for the AXI3 read path (AR and R channels) in front of a single read-only AXI slave, e.g. the test-bench slave BFM or a memory port.
- Grants one read transaction at a time in round-robin order.
- Tags the slave-side ARID with the grant index and routes R beats back to the owner.
- Checks the returned beat count against ARLEN.

Parameters:
- ID_WIDTH, 4, master-side ID width; slave-side ID is ID_WIDTH+1 bits.
- AXI_DWIDTH, 64, read data width (32/64/128).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- Mx_ARID  in  ID_WIDTH  read address ID, x=0,1 (same set for each master below).
- Mx_ARADDR  in  32  read address.
- Mx_ARLEN  in  4  burst length minus 1.
- Mx_ARSIZE  in  3  beat size.
- Mx_ARBURST  in  2  burst type.
- Mx_ARVALID  in  1  address valid.
- Mx_ARREADY  out  1  address accepted.
- Mx_RID  out  ID_WIDTH  read ID returned to master.
- Mx_RDATA  out  AXI_DWIDTH  read data.
- Mx_RRESP  out  2  read response.
- Mx_RLAST  out  1  last beat.
- Mx_RVALID  out  1  beat valid.
- Mx_RREADY  in  1  master ready.
- S_ARID  out  ID_WIDTH+1  {grant index, master ARID}.
- S_ARADDR  out  32  registered address.
- S_ARLEN  out  4  registered length.
- S_ARSIZE  out  3  registered size.
- S_ARBURST  out  2  registered burst type.
- S_ARVALID  out  1  registered address valid.
- S_ARREADY  in  1  slave accepts address.
- S_RID  in  ID_WIDTH+1  slave read ID.
- S_RDATA  in  AXI_DWIDTH  slave read data.
- S_RRESP  in  2  slave read response.
- S_RLAST  in  1  slave last beat.
- S_RVALID  in  1  slave beat valid.
- S_RREADY  out  1  ready to slave.
- BUSY  out  1  high in ADDR and DATA states.
- LEN_ERR  out  1  one-cycle pulse on beat-count mismatch.

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - state=IDLE, priority pointer=M0.
  - S_ARVALID=0; S_AR* registers all zero.
  - Beat counter=0, LEN_ERR=0, BUSY=0.
  - All Mx_ARREADY, Mx_RVALID and S_RREADY are 0.
  - Reset mid-transaction abandons the burst with no completion to any master.
- States: IDLE, ADDR, DATA.
- IDLE, grant selection:
  - Only M0_ARVALID high -> grant M0; only M1 high -> grant M1.
  - Both high -> grant the master the priority pointer names.
  - Mx_ARREADY is combinational, high only in IDLE and only for the granted master; ARREADY may depend on ARVALID.
- IDLE, on a grant handshake, at the next edge:
  - Latch the granted AR fields into S_AR*.
  - S_ARID={grant, Mx_ARID}.
  - S_ARVALID=1, latch expected length=ARLEN, state=ADDR.
  - Master handshake to S_ARVALID latency: 1 cycle.
- ADDR:
  - S_AR* held stable, S_ARVALID=1 until S_ARREADY=1.
  - On that edge: S_ARVALID=0, beat counter=0, state=DATA.
  - No master ARREADY is asserted.
- DATA:
  - Granted master gets S_RDATA, S_RRESP and S_RLAST combinationally.
  - Granted master gets Mx_RID=S_RID[ID_WIDTH-1:0] and Mx_RVALID=S_RVALID.
  - S_RREADY = granted Mx_RREADY.
  - The other master has RVALID=0; its R data outputs are don't-care, driven 0.
  - Counter increments on each S_RVALID&S_RREADY beat, 4 bits, saturating at 15.
- Burst completion (RLAST handshake):
  - If counter != latched ARLEN, LEN_ERR=1 for exactly the next cycle.
  - Priority pointer = the other master; state=IDLE.
- Beats that arrive after the counter reaches ARLEN without RLAST are still forwarded; only RLAST ends a burst.
- S_RID upper bit is not checked; routing uses the latched grant.
- One dead IDLE cycle follows every burst.
- At most one outstanding transaction.
- BUSY = (state!=IDLE).

Test Plan:
- Single read: M0 ARVALID, ARID=3, ARADDR=0x100, ARLEN=0, slave ARREADY=1, returns one beat 0xAAAA5555AAAA5555 with RLAST.
  -> S_ARID=5'h03; M0 receives the data, RID=3.
  -> LEN_ERR stays 0; BUSY returns to 0.
- Contention: M0 and M1 both hold ARVALID from reset release, each issues 3 reads, ARLEN=1.
  -> Grant order M0,M1,M0,M1,M0,M1; M1 reads show S_ARID[4]=1.
  -> M0 never sees RVALID during an M1 burst.
- Backpressure: M1 ARLEN=3, M1_RREADY toggles 1,0,0,1,...
  -> S_RREADY mirrors it; exactly 4 beats delivered in order; RLAST on beat 4; LEN_ERR=0.
- Address stall: S_ARREADY held 0 for 5 cycles.
  -> S_ARVALID and S_ARADDR stable throughout; no second master ARREADY; DATA is entered only after the handshake.
- Length error: ARLEN=3, slave asserts RLAST on beat 2.
  -> LEN_ERR pulses 1 cycle after that beat; state returns to IDLE; the next request is granted normally.
- Reset mid-burst: ARESET=1 after beat 1 of ARLEN=3.
  -> Next cycle all outputs at reset values, BUSY=0, pointer=M0; a fresh M1 request after release is granted.
